tone_arbiter: RTL and testbench
===============================

// Module: tone_arbiter
// PURPOSE
//   Shares one square-wave tone generator between N_REQ sound requesters (game
//   effects, score jingles, scale player). Each request carries a pitch
//   (half-period in clocks) and a duration in ms. The block grants one request
//   at a time, plays it for exactly its duration, then inserts a silent gap.
//   Sits between the game/sequencer logic and the speaker pin.
// PARAMETERS
//   N_REQ     4           number of requesters (2..8)
//   CLK_FREQ  50_000_000  clk frequency in Hz; ms tick = CLK_FREQ/1000 clocks
//   PW        20          half-period field width (clocks)
//   DW        16          duration field width (ms)
//   GAP_MS    10          silent gap after each note, ms (0 = no gap)
// PORTS
//   clk             in   1          system clock
//   resetn          in   1          asynchronous reset, active low
//   req             in   N_REQ      level request per requester
//   half_period_in  in   N_REQ*PW   pitch per requester, slice i = [i*PW +: PW]
//   dur_ms_in       in   N_REQ*DW   duration per requester, slice i = [i*DW +: DW]
//   ack             out  N_REQ      1-cycle pulse: request i accepted, fields latched
//   done            out  N_REQ      1-cycle pulse: note i finished
//   busy            out  1          high in every state except IDLE
//   active_id       out  clog2(N_REQ)  index of granted requester (held after note)
//   speaker         out  1          square-wave output
// BEHAVIOUR
//   - Reset (async, resetn=0): FSM=IDLE, ack/done/busy/active_id/speaker=0,
//     all counters 0, RR pointer 0. Mid-note reset silences speaker immediately.
//   - FSM IDLE -> PLAY -> GAP -> IDLE, all outputs registered.
//   - IDLE: if |req at cycle t, winner chosen combinationally. At t+1: ack[w]=1,
//     hp/dur latched, active_id=w, state=PLAY (or see dur=0). No req: stay.
//   - PLAY: tone_en=1 while latched hp!=0. The ms prescaler clears on PLAY entry,
//     so note length = dur*CLK_FREQ/1000 clocks exactly. On the last clock:
//     done[w]=1 for 1 cycle, next state = GAP (IDLE if GAP_MS=0).
//   - GAP: speaker=0 for GAP_MS*CLK_FREQ/1000 clocks, then IDLE.
//   - dur=0: ack at t+1, done at t+2, no PLAY, no gap, return to IDLE.
//   - hp=0: a rest. Speaker stays 0 and timing/done behave as a normal note.
//   - req withdrawn after ack: ignored, the note plays to completion. req held
//     after done: re-arbitrated in the next IDLE (one IDLE cycle minimum).
//   - req/fields changing during PLAY/GAP: no effect; fields are sampled only
//     when the grant is made.
//   - Tone gen: counter cleared and speaker=0 while tone_en=0. Otherwise speaker
//     toggles when count reaches hp-1, then count resets to 0. Phase starts at 0
//     at each note. Output period = 2*hp clocks.
//   - Widths: prescaler width is clog2(CLK_FREQ/1000). ms counter width is DW.
//     No overflow: the counter is compared for equality against the latched dur.
// CONFIGURATION
//   TONE_ARB_RR_EN defined: round-robin arbitration. Search starts at
//     (last granted + 1) mod N_REQ. Pointer updates on each ack.
//   Not defined: fixed priority, requester 0 highest. No pointer is implemented.
// STRUCTURE
//   - Package tone_arb_pkg: FSM state enum (IDLE, PLAY, GAP), the
//     MS_TICKS = CLK_FREQ/1000 constant, and the GAP_TICKS derivation.
//   - Sub-module tone_gen (clk, resetn, en, half_period, speaker): half-period
//     counter and toggle flop. It is instantiated once.
//   - Arbiter, FSM and duration timer stay in tone_arbiter.
// TESTING (sim with CLK_FREQ=10_000 -> 10 clk/ms, GAP_MS=1, N_REQ=4)
//   1. req[0], hp=5, dur=3 -> ack[0] next cycle. Speaker toggles every 5 clk for
//      30 clk (3 periods). done[0] pulses on clk 30. Speaker is silent 10 clk.
//   2. req[0]+req[2] both held -> fixed: 0,0,0... (2 is starved). With
//      TONE_ARB_RR_EN: grants alternate 0,2,0,2 and active_id tracks them.
//   3. dur=0 on req[1] -> ack[1] at t+1, done[1] at t+2, speaker never toggles,
//      busy high 1 cycle.
//   4. hp=0, dur=2 -> speaker 0 throughout. done exactly 20 clk after ack.
//   5. resetn low for 3 clk mid-PLAY -> speaker/busy 0 asynchronously. After
//      release with req[3] held: fresh ack[3] and full-length note.
//   6. req[0] dropped 1 clk after ack, dur=4 -> note still lasts 40 clk and
//      done[0] pulses; no re-grant afterward.

Source files
------------

// File: rtl/tone_arb_pkg.sv
// Shared types and timing derivations for the tone arbiter.
// No logic: FSM state encoding plus helpers that turn Hz/ms settings into
// clock counts and counter widths.
package tone_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Clocks per millisecond (MS_TICKS = CLK_FREQ/1000).
  function automatic int ms_ticks(input int clk_freq);
    return clk_freq / 1000;
  endfunction

  // Clocks of enforced silence after each note.
  function automatic int gap_ticks(input int clk_freq, input int gap_ms);
    return gap_ms * ms_ticks(clk_freq);
  endfunction

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tone_arbiter_if.sv
// Requester-side bus of the tone arbiter: level requests with per-requester
// pitch/duration fields, and the ack/done pulses, busy, grant id and speaker.
// master = game/sequencer side, slave = arbiter side.
interface tone_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int PW    = 20,
  parameter int DW    = 16
);
  localparam int AW = (N_REQ <= 2) ? 1 : $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*PW-1:0] half_period_in;
  logic [N_REQ*DW-1:0] dur_ms_in;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    done;
  logic                busy;
  logic [AW-1:0]       active_id;
  logic                speaker;

  modport master (
    output req, half_period_in, dur_ms_in,
    input  ack, done, busy, active_id, speaker
  );

  modport slave (
    input  req, half_period_in, dur_ms_in,
    output ack, done, busy, active_id, speaker
  );

endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: speaker toggles every half_period clocks while en=1.
// Ports: clk, resetn (async, active low), en, half_period, speaker (registered).
// Dropping en clears the phase counter and silences the output on the next edge.
module tone_gen #(
  parameter int PW = 20
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [PW-1:0] half_period,
  output logic          speaker
);

  logic [PW-1:0] cnt;

  // Caller guarantees half_period != 0 whenever en is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (cnt == half_period - PW'(1)) begin
      cnt     <= '0;
      speaker <= ~speaker;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Shares one tone generator among N_REQ requesters: grant, play for exactly
// dur ms, then a silent gap. Ports: clk, resetn (async, active low), bus (slave).
// Grant-to-ack 1 clk; requests are level and simply wait while busy.
// Optional macro TONE_ARB_RR_EN: round-robin arbitration (default: fixed, 0 highest).
module tone_arbiter
  import tone_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CLK_FREQ = 50_000_000,
  parameter int PW       = 20,
  parameter int DW       = 16,
  parameter int GAP_MS   = 10
) (
  input  logic         clk,
  input  logic         resetn,
  tone_arbiter_if.slave bus
);

  localparam int AW        = cnt_width(N_REQ);
  localparam int MS_TICKS  = ms_ticks(CLK_FREQ);
  localparam int SW        = cnt_width(MS_TICKS);
  localparam int GAP_TICKS = gap_ticks(CLK_FREQ, GAP_MS);
  localparam int GW        = cnt_width(GAP_TICKS);

  localparam logic [SW-1:0] PRE_LAST = SW'(MS_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    hp_q;
  logic [DW-1:0]    dur_q;
  logic [AW-1:0]    id_q;
  logic [SW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    ms_q, ms_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q;
  logic             grant;
  logic             note_last;
  logic             tone_en;
  logic [AW-1:0]    start;
  logic [AW-1:0]    win;

  // ---------------- arbitration ----------------
`ifdef TONE_ARB_RR_EN
  // ptr_q holds where the next search starts: last winner + 1.
  logic [AW-1:0] ptr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (int'(win) == N_REQ - 1) ? '0 : win + AW'(1);
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  // Scan from the farthest candidate back to start so the closest one wins.
  always_comb begin
    logic [AW-1:0] idx;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = AW'((int'(start) + k) % N_REQ);
      if (bus.req[idx]) win = idx;
    end
  end

  // ---------------- FSM ----------------
  // Last PLAY clock; a zero duration finishes on its first PLAY clock.
  assign note_last = (state_q == PLAY) &&
                     ((dur_q == '0) ||
                      ((presc_q == PRE_LAST) && (ms_q == dur_q - DW'(1))));

  // Tone is cut on the last clock so the generator's clear lands exactly at
  // the end of the note and no stray toggle leaks into the gap.
  assign tone_en = (state_q == PLAY) && (hp_q != '0) && !note_last;

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    done_d  = '0;
    grant   = 1'b0;
    presc_d = presc_q;
    ms_d    = ms_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant      = 1'b1;
          ack_d[win] = 1'b1;
          state_d    = PLAY;
          presc_d    = '0;
          ms_d       = '0;
        end
      end
      PLAY: begin
        if (note_last) begin
          done_d[id_q] = 1'b1;
          presc_d      = '0;
          ms_d         = '0;
          gap_d        = '0;
          state_d      = ((dur_q == '0) || (GAP_TICKS == 0)) ? IDLE : GAP;
        end else if (presc_q == PRE_LAST) begin
          presc_d = '0;
          ms_d    = ms_q + DW'(1);
        end else begin
          presc_d = presc_q + SW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      hp_q    <= '0;
      dur_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      // Fields are sampled only at grant; later changes are ignored.
      if (grant) begin
        hp_q  <= bus.half_period_in[int'(win)*PW +: PW];
        dur_q <= bus.dur_ms_in[int'(win)*DW +: DW];
        id_q  <= win;
      end
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = id_q;

  tone_gen #(.PW(PW)) u_tone_gen (
    .clk         (clk),
    .resetn      (resetn),
    .en          (tone_en),
    .half_period (hp_q),
    .speaker     (bus.speaker)
  );

endmodule

// File: tb/tb_tone_arbiter.sv
module tb_tone_arbiter;
  localparam int N  = 4;
  localparam int PW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  tone_arbiter_if #(.N_REQ(N), .PW(PW), .DW(DW)) bus ();

  tone_arbiter #(
    .N_REQ(N), .CLK_FREQ(10_000), .PW(PW), .DW(DW), .GAP_MS(1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id; int hp; int dur;
    int len; int rises; int high; int gap;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input int hp, input int dur);
    bus.half_period_in[id*PW +: PW] = PW'(hp);
    bus.dur_ms_in[id*DW +: DW]      = DW'(dur);
    bus.req[id]                     = 1'b1;
  endtask

  // Waits (bounded) for an ack; returns the granted index or -1.
  task automatic wait_ack(output int id, output int lat, output int av);
    id = -1; lat = 0; av = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.ack != '0) begin
        av = int'(bus.ack);
        for (int b = 0; b < N; b++) if (bus.ack[b]) id = b;
        break;
      end
    end
  endtask

  // Starts at the ack cycle; measures note length, speaker activity, gap.
  task automatic measure(input int id, input bit drop_late,
                         output int len, output int rises, output int high,
                         output int gap, output int gap_spk, output int dv);
    logic prev;
    len = 0; rises = 0; high = 0; gap = 0; gap_spk = 0; dv = 0;
    prev = bus.speaker;
    if (prev) high++;
    while (len < 2000) begin
      @(negedge clk);
      len++;
      if (drop_late && len == 1) bus.req[id] = 1'b0;
      if (bus.done != '0) begin
        dv = int'(bus.done);
        break;
      end
      if (bus.speaker) begin
        high++;
        if (!prev) rises++;
      end
      prev = bus.speaker;
    end
    while (bus.busy && gap < 200) begin
      if (bus.speaker) gap_spk++;
      @(negedge clk);
      gap++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int id, lat, av, len, rises, high, gap, gsp, dv;
    set_req(v.id, v.hp, v.dur);
    wait_ack(id, lat, av);
    bus.req[v.id] = 1'b0;
    chk("ack_latency", lat, 1);
    chk("ack_vector", av, 1 << v.id);
    chk("active_id", int'(bus.active_id), v.id);
    measure(v.id, 1'b0, len, rises, high, gap, gsp, dv);
    chk("note_len", len, v.len);
    chk("done_vector", dv, 1 << v.id);
    chk("spk_rises", rises, v.rises);
    chk("spk_high", high, v.high);
    chk("gap_len", gap, v.gap);
    chk("gap_silent", gsp, 0);
    @(negedge clk);
  endtask

  initial begin
    vec_t vt[6];
    int exp_seq[4];
    int id, lat, av, len, rises, high, gap, gsp, dv, cnt;

    //       id hp dur  len rises high gap
    vt[0] = '{0, 5, 3,  30, 3,    15,  10};
    vt[1] = '{1, 0, 0,  1,  0,    0,   0};
    vt[2] = '{2, 0, 2,  20, 0,    0,   10};
    vt[3] = '{3, 4, 2,  20, 2,    8,   10};
    vt[4] = '{2, 1, 1,  10, 5,    5,   10};
    vt[5] = '{1, 3, 1,  10, 2,    4,   10};

`ifdef TONE_ARB_RR_EN
    exp_seq = '{0, 2, 0, 2};
`else
    exp_seq = '{0, 0, 0, 0};
`endif

    bus.req = '0;
    bus.half_period_in = '0;
    bus.dur_ms_in = '0;

    // Reset state.
    #2 resetn = 1'b0;
    #10;
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_active_id", int'(bus.active_id), 0);
    chk("rst_speaker", int'(bus.speaker), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Table of single notes.
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Two contending requesters held continuously.
    set_req(0, 2, 1);
    set_req(2, 2, 1);
    for (int i = 0; i < 4; i++) begin
      wait_ack(id, lat, av);
      if (i == 3) bus.req = '0;
      chk("arb_grant", id, exp_seq[i]);
      chk("arb_active_id", int'(bus.active_id), exp_seq[i]);
      cnt = 0;
      while (bus.busy && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      chk("arb_note_cycles", cnt, 20);
    end

    // Reset in the middle of a note, request still held.
    @(negedge clk);
    set_req(3, 5, 3);
    wait_ack(id, lat, av);
    repeat (7) @(negedge clk);
    chk("pre_reset_speaker", int'(bus.speaker), 1);
    resetn = 1'b0;
    #1;
    chk("reset_speaker", int'(bus.speaker), 0);
    chk("reset_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_ack(id, lat, av);
    bus.req[3] = 1'b0;
    chk("post_reset_ack", av, 8);
    chk("post_reset_lat", lat, 1);
    measure(3, 1'b0, len, rises, high, gap, gsp, dv);
    chk("post_reset_len", len, 30);
    chk("post_reset_rises", rises, 3);
    chk("post_reset_done", dv, 8);

    // Request withdrawn one clock after ack.
    @(negedge clk);
    set_req(0, 7, 4);
    wait_ack(id, lat, av);
    chk("drop_ack", av, 1);
    measure(0, 1'b1, len, rises, high, gap, gsp, dv);
    chk("drop_len", len, 40);
    chk("drop_done", dv, 1);
    chk("drop_rises", rises, 3);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.busy) cnt++;
    end
    chk("drop_no_regrant", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
